// File: rtl/ms_rd_slave_if.sv
// Read/write link between a master and the read-side responder.
// Carries the bank write port, the read request, and the response handshake.
interface ms_rd_slave_if #(
  parameter int AW = 2,
  parameter int DW = 8
) ();

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rreq;
  logic [AW-1:0] raddr;
  logic          rack;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          rready;
  logic          busy;

  modport master (
    output wr_en, wr_addr, wr_data, rreq, raddr, rready,
    input  rack, rvalid, rdata, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rreq, raddr, rready,
    output rack, rvalid, rdata, busy
  );

endinterface

// File: rtl/ms_rd_slave.sv
// Read-side responder: holds a small register bank loaded by the write side
// and answers single-beat read requests after RD_LAT cycles on a
// valid/ready response channel.
module ms_rd_slave #(
  parameter int AW     = 2,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  ms_rd_slave_if.slave bus
);

  localparam int         DEPTH    = 2 ** AW;
  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic          busy_q;
  logic [DW-1:0] bank_q [DEPTH];

  logic          rack;
  logic          accept;
  logic [DW-1:0] rdata_d;

  // The link is ready for a new request when idle, or when the current
  // response is being taken on this same edge (back-to-back case).
  assign rack   = !rst && ((state_q == S_IDLE) || ((state_q == S_RESP) && bus.rready));
  assign accept = bus.rreq && rack;

  // A write landing on the load edge to the pending address wins over the
  // stored value, so the master always sees the freshest data.
  assign rdata_d = (bus.wr_en && (bus.wr_addr == addr_q)) ? bus.wr_data : bank_q[addr_q];

  assign bus.rack   = rack;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;

  // Register bank: written whenever the write strobe is high, regardless of
  // what the read side is doing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      bank_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read FSM: capture address on accept, count down the latency, load the
  // response at the end of the wait, then hold it until the master takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= bus.raddr;
            cnt_q   <= CNT_INIT;
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= 1'b1;
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rready) begin
            rvalid_q <= 1'b0;
            if (accept) begin
              addr_q  <= bus.raddr;
              cnt_q   <= CNT_INIT;
              state_q <= S_WAIT;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          rvalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_rd_slave.sv
// Bench for ms_rd_slave: one instance with RD_LAT=1 and one with RD_LAT=3
// share the write port; read requests go only to the selected instance.
module tb_ms_rd_slave;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       wrEn;
  logic [1:0] wrAddr;
  logic [7:0] wrData;
  logic       rreq;
  logic [1:0] raddr;
  logic       rready;

  logic       rackS;
  logic       rvalidS;
  logic [7:0] rdataS;
  logic       busyS;

  logic [7:0] mBank [4];
  int         total;
  int         passed;
  int         failed;

  ms_rd_slave_if #(.AW(2), .DW(8)) busA ();
  ms_rd_slave_if #(.AW(2), .DW(8)) busB ();

  ms_rd_slave #(.AW(2), .DW(8), .RD_LAT(1)) uLat1 (.clk(clk), .rst(rst), .bus(busA));
  ms_rd_slave #(.AW(2), .DW(8), .RD_LAT(3)) uLat3 (.clk(clk), .rst(rst), .bus(busB));

  assign busA.wr_en   = wrEn;
  assign busA.wr_addr = wrAddr;
  assign busA.wr_data = wrData;
  assign busA.rreq    = rreq & ~sel;
  assign busA.raddr   = raddr;
  assign busA.rready  = rready;
  assign busB.wr_en   = wrEn;
  assign busB.wr_addr = wrAddr;
  assign busB.wr_data = wrData;
  assign busB.rreq    = rreq & sel;
  assign busB.raddr   = raddr;
  assign busB.rready  = rready;

  assign rackS   = sel ? busB.rack   : busA.rack;
  assign rvalidS = sel ? busB.rvalid : busA.rvalid;
  assign rdataS  = sel ? busB.rdata  : busA.rdata;
  assign busyS   = sel ? busB.busy   : busA.busy;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and advance to the next falling edge; the
  // reference bank takes the write as the rising edge in between does.
  task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                               input logic rq, input logic [1:0] ra, input logic rr);
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    rreq   = rq;
    raddr  = ra;
    rready = rr;
    @(negedge clk);
    if (we) mBank[wa] = wd;
  endtask

  task automatic randWrite(input bit noise, output logic we, output logic [1:0] wa,
                           output logic [7:0] wd);
    we = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    wa = 2'($urandom_range(0, 3));
    wd = 8'($urandom);
  endtask

  // One complete read of address a on the selected instance: the response
  // must show up RD_LAT edges after accept with the bank contents as of the
  // load edge, stay frozen through the stall, and drop after the handshake.
  task automatic readCheck(input logic [1:0] a, input int stall, input bit noise);
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [7:0] expD;
    int         lat;
    int         expLat;
    expLat = sel ? 3 : 1;
    checkOutput("rack_idle", rackS, 1);
    randWrite(noise, we, wa, wd);
    applyStimulus(we, wa, wd, 1'b1, a, 1'b1);
    lat = 0;
    while (rvalidS !== 1'b1 && lat < 20) begin
      randWrite(noise, we, wa, wd);
      applyStimulus(we, wa, wd, 1'b0, a, 1'b1);
      lat++;
    end
    expD = mBank[a];
    checkOutput("rd_lat", lat, expLat);
    checkOutput("rd_data", rdataS, expD);
    for (int s = 0; s < stall; s++) begin
      randWrite(noise, we, wa, wd);
      applyStimulus(we, wa, wd, 1'b0, a, 1'b0);
      checkOutput("stall_rvalid", rvalidS, 1);
      checkOutput("stall_rdata", rdataS, expD);
      checkOutput("stall_rack", rackS, 0);
    end
    randWrite(noise, we, wa, wd);
    applyStimulus(we, wa, wd, 1'b0, a, 1'b1);
    checkOutput("done_rvalid", rvalidS, 0);
    checkOutput("done_busy", busyS, 0);
  endtask

  initial begin
    logic [7:0] initVals [4];
    total  = 0;
    passed = 0;
    failed = 0;
    initVals[0] = 8'h11;
    initVals[1] = 8'h22;
    initVals[2] = 8'h33;
    initVals[3] = 8'h44;
    for (int i = 0; i < 4; i++) mBank[i] = 8'h00;
    rst    = 1'b1;
    sel    = 1'b0;
    wrEn   = 1'b0;
    wrAddr = '0;
    wrData = '0;
    rreq   = 1'b0;
    raddr  = '0;
    rready = 1'b0;

    // Reset values on both instances, rack held low during reset.
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      rreq = 1'b1;
      #1;
      checkOutput("rst_rvalid", rvalidS, 0);
      checkOutput("rst_rdata", rdataS, 0);
      checkOutput("rst_busy", busyS, 0);
      checkOutput("rst_rack", rackS, 0);
    end
    rreq = 1'b0;
    sel  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel_rack", rackS, 1);

    // Load the bank.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), initVals[i], 1'b0, 2'd0, 1'b1);

    // Basic read of address 2 on the one-cycle instance.
    $display("[TB] basic read");
    checkOutput("basic_rack", rackS, 1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1);
    checkOutput("basic_wait_rvalid", rvalidS, 0);
    checkOutput("basic_wait_busy", busyS, 1);
    checkOutput("basic_wait_rack", rackS, 0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 1'b1);
    checkOutput("basic_rvalid", rvalidS, 1);
    checkOutput("basic_rdata", rdataS, 8'h33);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 1'b1);
    checkOutput("basic_fall", rvalidS, 0);
    checkOutput("basic_idle_busy", busyS, 0);

    // Back-to-back reads 0..3 with rreq and rready held high.
    $display("[TB] back-to-back");
    for (int i = 0; i < 4; i++) begin
      checkOutput("b2b_rack_hi", rackS, 1);
      if (i > 0) begin
        checkOutput("b2b_rvalid", rvalidS, 1);
        checkOutput("b2b_rdata", rdataS, mBank[i-1]);
      end
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'(i), 1'b1);
      checkOutput("b2b_rack_lo", rackS, 0);
      checkOutput("b2b_busy_wait", busyS, 1);
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'(i), 1'b1);
      checkOutput("b2b_busy_resp", busyS, 1);
    end
    checkOutput("b2b_last_rvalid", rvalidS, 1);
    checkOutput("b2b_last_rdata", rdataS, 8'h44);

    // Backpressure: hold the 0x44 response for five cycles.
    $display("[TB] backpressure");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 1'b0);
      checkOutput("bp_rvalid", rvalidS, 1);
      checkOutput("bp_rdata", rdataS, 8'h44);
      checkOutput("bp_rack", rackS, 0);
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 1'b1);
    checkOutput("bp_done_rvalid", rvalidS, 0);
    checkOutput("bp_done_busy", busyS, 0);

    // Write and accept to the same address on the same edge.
    applyStimulus(1'b1, 2'd0, 8'hC3, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    checkOutput("same_edge_rdata", rdataS, 8'hC3);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);

    // Forwarding on the three-cycle instance: write on the load edge.
    $display("[TB] forwarding");
    sel = 1'b1;
    applyStimulus(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1);
    checkOutput("fwd_early_rvalid", rvalidS, 0);
    applyStimulus(1'b1, 2'd1, 8'hA5, 1'b0, 2'd1, 1'b1);
    checkOutput("fwd_rvalid", rvalidS, 1);
    checkOutput("fwd_rdata", rdataS, 8'hA5);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1);
    checkOutput("fwd_done_busy", busyS, 0);

    // Same, with the write one cycle earlier, during the wait.
    applyStimulus(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1);
    applyStimulus(1'b1, 2'd1, 8'hA5, 1'b0, 2'd1, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1);
    checkOutput("fwd2_rvalid", rvalidS, 1);
    checkOutput("fwd2_rdata", rdataS, 8'hA5);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1);

    // Randomized reads against the reference bank, with background writes
    // and random response stalls on both instances.
    $display("[TB] random reads");
    for (int n = 0; n < 24; n++) begin
      sel = 1'($urandom_range(0, 1));
      readCheck(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset during the wait on the one-cycle instance.
    $display("[TB] reset mid-operation");
    sel = 1'b0;
    applyStimulus(1'b1, 2'd3, 8'h5E, 1'b0, 2'd0, 1'b1);
    readCheck(2'd3, 0, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1);
    checkOutput("rw_pre_busy", busyS, 1);
    rreq = 1'b0;
    rst  = 1'b1;
    #1;
    checkOutput("rw_rvalid", rvalidS, 0);
    checkOutput("rw_rdata", rdataS, 0);
    checkOutput("rw_busy", busyS, 0);
    checkOutput("rw_rack", rackS, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mBank[i] = 8'h00;
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    checkOutput("rw_no_replay", rvalidS, 0);
    readCheck(2'd3, 0, 1'b0);

    // Reset while holding a response on the three-cycle instance.
    sel = 1'b1;
    applyStimulus(1'b1, 2'd2, 8'h77, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 1'b0);
    checkOutput("rr_pre_rvalid", rvalidS, 1);
    checkOutput("rr_pre_rdata", rdataS, 8'h77);
    rst = 1'b1;
    #1;
    checkOutput("rr_rvalid", rvalidS, 0);
    checkOutput("rr_rdata", rdataS, 0);
    checkOutput("rr_busy", busyS, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mBank[i] = 8'h00;
    rready = 1'b1;
    @(negedge clk);
    checkOutput("rr_no_replay", rvalidS, 0);
    for (int i = 0; i < 4; i++) readCheck(2'(i), 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
